// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage fed by the EX->MEM register.
// Runs a req/gnt/rvalid data port and emits a one-cycle WB result.
module mem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      ex_valid_i,
    output logic                      mem_ready_o,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic [DATA_WIDTH-1:0]     store_data_i,
    input  logic                      mem_re_i,
    input  logic                      mem_we_i,
    input  logic [1:0]                mem_size_i,
    input  logic                      mem_unsigned_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                      rd_we_i,
    output logic                      data_req_o,
    input  logic                      data_gnt_i,
    output logic [ADDR_WIDTH-1:0]     data_addr_o,
    output logic                      data_we_o,
    output logic [3:0]                data_be_o,
    output logic [DATA_WIDTH-1:0]     data_wdata_o,
    input  logic                      data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     data_rdata_i,
    input  logic                      data_err_i,
    output logic                      wb_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_o,
    output logic                      wb_rd_we_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic                      wb_misaligned_o,
    output logic                      wb_bus_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     addr;
        logic [DATA_WIDTH-1:0]     wdata;
        logic                      we;
        logic [1:0]                size;
        logic                      uns;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      rd_we;
    } req_t;

    state_e state_q, state_d;
    req_t   req_q;
    logic   stale_q;

    logic                  accept;
    logic                  is_mem;
    logic                  misaligned;
    logic [1:0]            off;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] rdata_sh;
    logic [DATA_WIDTH-1:0] load_val;

    assign accept   = ex_valid_i && mem_ready_o;
    assign is_mem   = mem_re_i || mem_we_i;
    assign off      = req_q.addr[1:0];
    assign wdata_sh = req_q.wdata << {off, 3'b000};
    assign rdata_sh = data_rdata_i >> {off, 3'b000};

    always_comb begin
        misaligned = 1'b1;
        unique case (mem_size_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = alu_result_i[0];
            2'b10:   misaligned = |alu_result_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        be = 4'b1111;
        unique case (req_q.size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        load_val = rdata_sh;
        unique case (req_q.size)
            2'b00: load_val = {{(DATA_WIDTH-8){~req_q.uns & rdata_sh[7]}},
                               rdata_sh[7:0]};
            2'b01: load_val = {{(DATA_WIDTH-16){~req_q.uns & rdata_sh[15]}},
                               rdata_sh[15:0]};
            default: load_val = rdata_sh;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && is_mem && !misaligned) state_d = REQ;
            REQ:     if (data_gnt_i) state_d = RESP;
            RESP:    if (data_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_ready_o  = 1'b0;
        data_req_o   = 1'b0;
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_wdata_o = '0;
        unique case (state_q)
            IDLE: mem_ready_o = 1'b1;
            REQ: begin
                data_req_o   = 1'b1;
                data_addr_o  = {req_q.addr[ADDR_WIDTH-1:2], 2'b00};
                data_we_o    = req_q.we;
                data_be_o    = be;
                data_wdata_o = wdata_sh;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= '{addr: alu_result_i, wdata: store_data_i,
                       we: mem_we_i, size: mem_size_i,
                       uns: mem_unsigned_i, rd_addr: rd_addr_i,
                       rd_we: rd_we_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wb_valid_o      <= 1'b0;
            wb_rd_addr_o    <= '0;
            wb_rd_we_o      <= 1'b0;
            wb_data_o       <= '0;
            wb_misaligned_o <= 1'b0;
            wb_bus_err_o    <= 1'b0;
        end else begin
            wb_valid_o      <= 1'b0;
            wb_rd_addr_o    <= '0;
            wb_rd_we_o      <= 1'b0;
            wb_data_o       <= '0;
            wb_misaligned_o <= 1'b0;
            wb_bus_err_o    <= 1'b0;
            if (accept && !(is_mem && !misaligned)) begin
                wb_valid_o      <= 1'b1;
                wb_rd_addr_o    <= rd_addr_i;
                wb_data_o       <= alu_result_i;
                wb_rd_we_o      <= !is_mem && rd_we_i;
                wb_misaligned_o <= is_mem;
            end else if (state_q == RESP && data_rvalid_i) begin
                wb_valid_o   <= 1'b1;
                wb_rd_addr_o <= req_q.rd_addr;
                if (data_err_i) begin
                    wb_bus_err_o <= 1'b1;
                    wb_data_o    <= req_q.addr;
                end else if (!req_q.we) begin
                    wb_rd_we_o <= req_q.rd_we;
                    wb_data_o  <= load_val;
                end
            end
        end
    end

    // A reset that aborts a transaction may leave one response in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            stale_q <= stale_q || (state_q != IDLE);
        else if (data_rvalid_i || state_q == REQ)
            stale_q <= 1'b0;
    end

    a_rvalid_in_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_rvalid_i |-> (state_q == RESP || stale_q));

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage
// against a byte-level reference model of the MEM stage.
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        mem_ready_o;
    logic [31:0] alu_result_i = '0;
    logic [31:0] store_data_i = '0;
    logic        mem_re_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [1:0]  mem_size_i = '0;
    logic        mem_unsigned_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic        rd_we_i = 1'b0;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic        data_err_i = 1'b0;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_addr_o;
    logic        wb_rd_we_o;
    logic [31:0] wb_data_o;
    logic        wb_misaligned_o;
    logic        wb_bus_err_o;

    mem_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .mem_ready_o(mem_ready_o),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
        .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .data_err_i(data_err_i),
        .wb_valid_o(wb_valid_o), .wb_rd_addr_o(wb_rd_addr_o),
        .wb_rd_we_o(wb_rd_we_o), .wb_data_o(wb_data_o),
        .wb_misaligned_o(wb_misaligned_o), .wb_bus_err_o(wb_bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wb_data;
        logic        wb_we;
        logic        mis;
        logic        berr;
        logic [15:0] lat;
    } exp_t;

    // Observations from one transaction
    logic        o_req_seen, o_we, o_unstable, o_to, o_after;
    logic [31:0] o_addr, o_wdata, o_wb_data;
    logic [3:0]  o_be;
    logic [4:0]  o_wb_rd;
    logic        o_wb_we, o_wb_mis, o_wb_berr;
    int          o_req_cycles, o_lat, o_ready_busy;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic exp_t model(input logic [31:0] a,
                                   input logic re, input logic we,
                                   input logic [1:0] sz, input logic un,
                                   input logic rw, input int gd,
                                   input int rv, input logic [31:0] rdat,
                                   input logic er);
        exp_t e;
        int off, nb;
        longint v, span;
        e   = '0;
        off = int'(a % 32'd4);
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (!(re || we)) begin
            e.wb_data = a;
            e.wb_we   = rw;
            e.lat     = 16'd1;
        end else if (sz == 2'd3 || (off % nb) != 0) begin
            e.mis     = 1'b1;
            e.wb_data = a;
            e.lat     = 16'd1;
        end else begin
            e.req  = 1'b1;
            e.addr = a - 32'(off);
            for (int i = 0; i < nb; i++) e.be[off+i] = 1'b1;
            e.lat = 16'(3 + gd + rv);
            if (er) begin
                e.berr    = 1'b1;
                e.wb_data = a;
            end else if (we) begin
                e.wb_data = '0;
            end else begin
                span = longint'(1) << (8 * nb);
                v = (longint'(rdat) / (longint'(1) << (8 * off))) % span;
                if (!un && nb < 4 && v >= span / 2) v = v - span;
                e.wb_data = v[31:0];
                e.wb_we   = rw;
            end
        end
        return e;
    endfunction

    // Issue one instruction and act as the data memory until WB fires.
    task automatic run_op(input logic [31:0] a, input logic [31:0] sd,
                          input logic re, input logic we,
                          input logic [1:0] sz, input logic un,
                          input logic [4:0] rd, input logic rw,
                          input int gd, input int rv,
                          input logic [31:0] rdat, input logic er);
        int gc, rc;
        logic granted;
        o_req_seen = 0; o_we = 0; o_unstable = 0; o_to = 1; o_after = 0;
        o_addr = '0; o_wdata = '0; o_be = '0;
        o_wb_data = '0; o_wb_rd = '0;
        o_wb_we = 0; o_wb_mis = 0; o_wb_berr = 0;
        o_req_cycles = 0; o_lat = 1; o_ready_busy = 0;
        ex_valid_i = 1; alu_result_i = a; store_data_i = sd;
        mem_re_i = re; mem_we_i = we; mem_size_i = sz;
        mem_unsigned_i = un; rd_addr_i = rd; rd_we_i = rw;
        tick();
        ex_valid_i = 0; alu_result_i = $urandom; store_data_i = $urandom;
        mem_re_i = 0; mem_we_i = 0; mem_size_i = 2'($urandom);
        rd_addr_i = 5'($urandom); rd_we_i = 1'($urandom);
        gc = 0; rc = 0; granted = 0;
        for (int i = 0; i < 60; i++) begin
            data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0;
            data_rdata_i = $urandom;
            if (wb_valid_o) begin
                o_wb_data = wb_data_o; o_wb_rd = wb_rd_addr_o;
                o_wb_we = wb_rd_we_o; o_wb_mis = wb_misaligned_o;
                o_wb_berr = wb_bus_err_o; o_to = 0;
                break;
            end
            if (mem_ready_o) o_ready_busy++;
            if (data_req_o) begin
                if (!o_req_seen) begin
                    o_addr = data_addr_o; o_be = data_be_o;
                    o_we = data_we_o; o_wdata = data_wdata_o;
                end else if (o_addr !== data_addr_o || o_be !== data_be_o ||
                             o_we !== data_we_o || o_wdata !== data_wdata_o) begin
                    o_unstable = 1;
                end
                o_req_seen = 1;
                o_req_cycles++;
                if (gc == gd) begin
                    data_gnt_i = 1;
                    granted = 1;
                end
                gc++;
            end else if (granted) begin
                if (rc == rv) begin
                    data_rvalid_i = 1; data_rdata_i = rdat; data_err_i = er;
                end
                rc++;
            end
            tick();
            o_lat++;
        end
        data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0;
        tick();
        o_after = wb_valid_o;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        tick(); tick();
        n_vec++;
        if (mem_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got %b exp 1", mem_ready_o);
        end
        n_vec++;
        if ({data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
             wb_valid_o, wb_rd_addr_o, wb_rd_we_o, wb_data_o,
             wb_misaligned_o, wb_bus_err_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got req=%b addr=%h wbv=%b wbd=%h exp all 0",
                     data_req_o, data_addr_o, wb_valid_o, wb_data_o);
        end
        rst_ni = 1;
        tick();
    endtask

    task automatic test_nonmem();
        run_op(32'h0000_1234, '0, 0, 0, 2'b10, 0, 5'd5, 1, 0, 0, '0, 0);
        n_vec++;
        if ({o_to, o_wb_data, o_wb_rd, o_wb_we, o_wb_mis, o_wb_berr} !==
            {1'b0, 32'h1234, 5'd5, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL nonmem_wb got to=%b d=%h rd=%0d we=%b exp d=1234 rd=5 we=1",
                     o_to, o_wb_data, o_wb_rd, o_wb_we);
        end
        n_vec++;
        if ({o_req_seen, 16'(o_lat), o_after} !== {1'b0, 16'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL nonmem_timing got req=%b lat=%0d after=%b exp 0/1/0",
                     o_req_seen, o_lat, o_after);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [6];
        for (int i = 0; i < 6; i++) begin
            v[i] = $urandom;
            ex_valid_i = 1; alu_result_i = v[i];
            mem_re_i = 0; mem_we_i = 0; rd_addr_i = 5'(i + 1); rd_we_i = 1;
            tick();
            n_vec++;
            if ({wb_valid_o, wb_data_o, wb_rd_addr_o, mem_ready_o} !==
                {1'b1, v[i], 5'(i + 1), 1'b1}) begin
                n_bad++;
                $display("FAIL b2b[%0d] got v=%b d=%h rd=%0d rdy=%b exp d=%h",
                         i, wb_valid_o, wb_data_o, wb_rd_addr_o, mem_ready_o, v[i]);
            end
        end
        ex_valid_i = 0;
        tick();
    endtask

    task automatic test_lb();
        run_op(32'h103, $urandom, 1, 0, 2'b00, 0, 5'd7, 1, 0, 0,
               32'h80AA_BBCC, 0);
        n_vec++;
        if ({o_req_seen, o_addr, o_be, o_we} !==
            {1'b1, 32'h100, 4'b1000, 1'b0}) begin
            n_bad++;
            $display("FAIL lb_bus got req=%b addr=%h be=%b we=%b exp 1/100/1000/0",
                     o_req_seen, o_addr, o_be, o_we);
        end
        n_vec++;
        if ({o_to, o_wb_data, o_wb_we, o_wb_rd, 16'(o_lat), o_after} !==
            {1'b0, 32'hFFFF_FF80, 1'b1, 5'd7, 16'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL lb_wb got d=%h we=%b rd=%0d lat=%0d exp ffffff80/1/7/3",
                     o_wb_data, o_wb_we, o_wb_rd, o_lat);
        end
        run_op(32'h103, $urandom, 1, 0, 2'b00, 1, 5'd7, 1, 0, 0,
               32'h80AA_BBCC, 0);
        n_vec++;
        if ({o_to, o_wb_data, o_wb_we} !== {1'b0, 32'h0000_0080, 1'b1}) begin
            n_bad++;
            $display("FAIL lbu_wb got d=%h we=%b exp 00000080/1", o_wb_data, o_wb_we);
        end
    endtask

    task automatic test_sh();
        run_op(32'h202, 32'h0000_BEEF, 0, 1, 2'b01, 0, 5'd9, 1, 3, 0,
               $urandom, 0);
        n_vec++;
        if ({16'(o_req_cycles), o_addr, o_be, o_we, o_wdata[31:16], o_unstable} !==
            {16'd4, 32'h200, 4'b1100, 1'b1, 16'hBEEF, 1'b0}) begin
            n_bad++;
            $display("FAIL sh_bus got n=%0d addr=%h be=%b we=%b wd=%h unst=%b",
                     o_req_cycles, o_addr, o_be, o_we, o_wdata, o_unstable);
        end
        n_vec++;
        if ({o_to, o_ready_busy == 0, o_wb_we, o_wb_data, 16'(o_lat)} !==
            {1'b0, 1'b1, 1'b0, 32'h0, 16'd6}) begin
            n_bad++;
            $display("FAIL sh_wb got to=%b rdybusy=%0d we=%b d=%h lat=%0d",
                     o_to, o_ready_busy, o_wb_we, o_wb_data, o_lat);
        end
    endtask

    task automatic test_misaligned();
        logic [1:0] szs [2];
        szs[0] = 2'b10; szs[1] = 2'b11;
        for (int i = 0; i < 2; i++) begin
            run_op(32'h006, '0, 1, 0, szs[i], 0, 5'd4, 1, 0, 0, '0, 0);
            n_vec++;
            if ({o_to, o_req_seen, o_wb_mis, o_wb_we, o_wb_berr, o_wb_data,
                 16'(o_lat)} !==
                {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h006, 16'd1}) begin
                n_bad++;
                $display("FAIL misaligned[sz=%b] got req=%b mis=%b we=%b d=%h lat=%0d",
                         szs[i], o_req_seen, o_wb_mis, o_wb_we, o_wb_data, o_lat);
            end
        end
    endtask

    task automatic test_bus_err();
        run_op(32'h40, '0, 1, 0, 2'b10, 0, 5'd2, 1, 1, 1, $urandom, 1);
        n_vec++;
        if ({o_to, o_wb_berr, o_wb_we, o_wb_mis, o_wb_data} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 32'h40}) begin
            n_bad++;
            $display("FAIL bus_err got berr=%b we=%b d=%h exp 1/0/00000040",
                     o_wb_berr, o_wb_we, o_wb_data);
        end
    endtask

    task automatic test_reset_mid();
        ex_valid_i = 1; alu_result_i = 32'h80; mem_re_i = 1; mem_we_i = 0;
        mem_size_i = 2'b10; rd_addr_i = 5'd3; rd_we_i = 1;
        tick();
        ex_valid_i = 0;
        n_vec++;
        if (data_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_req got %b exp 1", data_req_o);
        end
        data_gnt_i = 1;
        tick();
        data_gnt_i = 0;
        rst_ni = 0;
        tick();
        rst_ni = 1;
        tick();
        data_rvalid_i = 1; data_rdata_i = $urandom;
        tick();
        data_rvalid_i = 0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({mem_ready_o, wb_valid_o, wb_data_o, wb_rd_we_o, data_req_o} !==
                {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL rstmid[%0d] got rdy=%b wbv=%b d=%h req=%b",
                         i, mem_ready_o, wb_valid_o, wb_data_o, data_req_o);
            end
            tick();
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [31:0] a, sd, rdat;
        logic re, we, un, rw, er, bad;
        logic [1:0] sz;
        logic [4:0] rd;
        int gd, rv, kind, off;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 2);
            re = (kind == 1); we = (kind == 2);
            a  = $urandom & 32'h0000_0FFF;
            sd = $urandom; rdat = $urandom;
            sz = 2'($urandom_range(0, 3));
            un = 1'($urandom); rw = 1'($urandom);
            rd = 5'($urandom);
            er = ($urandom_range(0, 7) == 0);
            gd = $urandom_range(0, 3); rv = $urandom_range(0, 2);
            e = model(a, re, we, sz, un, rw, gd, rv, rdat, er);
            run_op(a, sd, re, we, sz, un, rd, rw, gd, rv, rdat, er);
            n_vec++;
            if ({o_wb_data, o_wb_we, o_wb_mis, o_wb_berr, o_wb_rd} !==
                {e.wb_data, e.wb_we, e.mis, e.berr, rd}) begin
                n_bad++;
                $display("FAIL rand_wb[%0d] got d=%h we=%b mis=%b be=%b rd=%0d exp d=%h we=%b mis=%b be=%b",
                         n, o_wb_data, o_wb_we, o_wb_mis, o_wb_berr, o_wb_rd,
                         e.wb_data, e.wb_we, e.mis, e.berr);
            end
            n_vec++;
            if ({o_to, 16'(o_lat), o_after} !== {1'b0, e.lat, 1'b0}) begin
                n_bad++;
                $display("FAIL rand_lat[%0d] got to=%b lat=%0d after=%b exp lat=%0d",
                         n, o_to, o_lat, o_after, e.lat);
            end
            n_vec++;
            if (e.req) begin
                if ({o_req_seen, o_addr, o_be, o_we, 16'(o_req_cycles),
                     o_unstable, o_ready_busy == 0} !==
                    {1'b1, e.addr, e.be, we, 16'(gd + 1), 1'b0, 1'b1}) begin
                    n_bad++;
                    $display("FAIL rand_bus[%0d] got addr=%h be=%b we=%b n=%0d exp addr=%h be=%b n=%0d",
                             n, o_addr, o_be, o_we, o_req_cycles,
                             e.addr, e.be, gd + 1);
                end
            end else if (o_req_seen !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_noreq[%0d] got req=%b exp 0", n, o_req_seen);
            end
            if (e.req && we) begin
                bad = 0;
                off = int'(a % 32'd4);
                for (int i = 0; i < 4; i++)
                    if (e.be[i] && o_wdata[8*i +: 8] !== 8'((sd >> (8 * (i - off))) & 32'hFF))
                        bad = 1;
                n_vec++;
                if (bad !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rand_wdata[%0d] got %h be=%b exp data %h off %0d",
                             n, o_wdata, e.be, sd, off);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nonmem();
        test_back_to_back();
        test_lb();
        test_sh();
        test_misaligned();
        test_bus_err();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage RISC-V core; receiving end of the EX→MEM pipeline register.
- Accepts ALU results and load/store requests from EX.
- Drives a req/gnt/rvalid data-memory port, aligns and extends load data, and emits a single-cycle MEM→WB result.
- Stalls EX through a ready signal while a memory transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, datapath and memory data width. Only 32 is supported.
- ADDR_WIDTH, 32, data-memory address width.
- REG_ADDR_WIDTH, 5, destination register index width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- ex_valid_i  in  1  EX presents a valid instruction
- mem_ready_o  out  1  MEM can accept this cycle
- alu_result_i  in  32  ALU result; this is the effective address for loads and stores
- store_data_i  in  32  rs2 value for stores
- mem_re_i  in  1  load
- mem_we_i  in  1  store; mem_re_i and mem_we_i are never both set
- mem_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- mem_unsigned_i  in  1  zero-extend the load (LBU/LHU)
- rd_addr_i  in  5  destination register
- rd_we_i  in  1  writes rd
- data_req_o  out  1  memory request
- data_gnt_i  in  1  request accepted
- data_addr_o  out  32  word-aligned address (bits [1:0] = 0)
- data_we_o  out  1  write
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  lane-aligned write data
- data_rvalid_i  in  1  response valid
- data_rdata_i  in  32  read data
- data_err_i  in  1  bus error, qualified by rvalid
- wb_valid_o  out  1  result valid, one-cycle pulse
- wb_rd_addr_o  out  5  destination register
- wb_rd_we_o  out  1  register write enable
- wb_data_o  out  32  result data
- wb_misaligned_o  out  1  misaligned or illegal-size access
- wb_bus_err_o  out  1  bus error on access

Behaviour:
- **Reset:** rst_ni is sampled on the clk_i edge. The FSM goes to IDLE and every output is 0, except mem_ready_o = 1 in IDLE.
- **FSM states:** IDLE, REQ, RESP.
- **Acceptance:**
  - mem_ready_o = (state == IDLE).
  - An instruction is accepted when ex_valid_i && mem_ready_o.
  - The accepted fields are captured into internal registers.
- **Non-memory instruction (re = we = 0):**
  - Next cycle: wb_valid_o = 1, wb_data_o = alu_result_i, wb_rd_we_o = rd_we_i.
  - Latency 1, throughput 1 per cycle; the FSM stays in IDLE.
- **Misalignment check, at acceptance:**
  - Misaligned if size = 01 and addr[0] = 1, or size = 10 and addr[1:0] ≠ 00.
  - size = 11 is treated as misaligned.
  - Result next cycle: wb_valid_o = 1, wb_misaligned_o = 1, wb_rd_we_o = 0, wb_data_o = address. No bus request is issued.
- **Legal load/store:**
  - Accept → REQ.
  - In REQ: data_req_o = 1, with addr/we/be/wdata held stable from registers until data_gnt_i.
  - gnt → RESP, and data_req_o drops in the following cycle.
  - In RESP: on data_rvalid_i → IDLE, and the WB outputs are registered on the next cycle.
  - Minimum latency (gnt in the first REQ cycle, rvalid the cycle after): accept at T, req at T+1, rvalid at T+2, wb_valid_o at T+3.
- **Byte enables:** byte → 0001 << addr[1:0]; half → 0011 << addr[1:0]; word → 1111.
- **Write data:** data_wdata_o = store_data << (8 × addr[1:0]). Lanes not enabled by data_be_o are don't-care.
- **Load data:**
  - Shift rdata right by 8 × addr[1:0].
  - Take 8 or 16 bits; sign-extend unless mem_unsigned is set. Word loads pass through unchanged.
- **Store completion:** stores also wait for rvalid. wb_valid_o pulses with wb_rd_we_o = 0 and wb_data_o = 0.
- **Bus error:** data_err_i with rvalid gives wb_bus_err_o = 1, wb_rd_we_o = 0, wb_data_o = address.
- **At most one outstanding transaction.** EX is stalled (mem_ready_o = 0) for all of REQ and RESP.
- **Ignored responses:** data_rvalid_i in IDLE or REQ is ignored; it is a protocol violation and is flagged by an assertion.
- **WB has no backpressure.** wb_* outputs are valid only while wb_valid_o = 1 and are 0 otherwise.
- **Reset mid-transaction:** the FSM returns to IDLE and data_req_o drops next cycle. A stale rvalid arriving after reset is ignored.

Test Plan:
1. Non-memory op: alu=0x0000_1234, rd=5, rd_we=1 → one cycle later wb_valid=1, wb_data=0x1234, wb_rd_addr=5; mem_ready stays 1.
2. LB from addr 0x103, rdata=0x80AA_BBCC, gnt at once, rvalid next cycle:
   - data_addr = 0x100, be = 1000.
   - wb_data = 0xFFFF_FF80 at T+3.
   - The same access with LBU gives 0x0000_0080.
3. SH of 0x0000_BEEF to 0x202 with gnt delayed 3 cycles:
   - req held 4 cycles, addr = 0x200, be = 1100, wdata[31:16] = 0xBEEF.
   - mem_ready = 0 until IDLE; wb_valid pulses with rd_we = 0.
4. LW from 0x006 → misaligned: no data_req, next-cycle wb_misaligned = 1, wb_rd_we = 0, wb_data = 0x006. The same applies for size = 11.
5. LW from 0x40 with rvalid + err → wb_bus_err = 1, wb_rd_we = 0, wb_data = 0x40.
6. Reset asserted in RESP, then rvalid one cycle after reset is released → outputs 0, mem_ready = 1, no wb_valid pulse.
